// File: rtl/clock_period_meter_pkg.sv
// Shared types and default sizing for the clock period meter and the divider test harness.
package clock_period_meter_pkg;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 4000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; emits one-cycle rise/fall pulses for an async input.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Both edges see the same pipeline depth, so measured intervals carry no bias.
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow async input in system-clock cycles,
// with stall timeout and a single-entry output buffer that flags dropped results.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             timeout_err,
    output logic             overrun,
    output state_t           dbg_state
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi_cap;
    state_t           state;
    state_t           state_next;
    logic             hi_load;
    logic             capture_req;
    logic             timeout_hit;
    logic             can_capture;

    sync_edge_detect u_sync (
        .clock  (clock),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // cnt holds the number of cycles since the last detected rise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= WIDTH'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        hi_load     = 1'b0;
        capture_req = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            SEEK: begin
                if (rise) state_next = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    hi_load    = 1'b1;
                    state_next = LOW;
                end else if (cnt == TIMEOUT_V) begin
                    timeout_hit = 1'b1;
                    state_next  = SEEK;
                end
            end
            LOW: begin
                // The closing rise also opens the next measurement.
                if (rise) begin
                    capture_req = 1'b1;
                    state_next  = HIGH;
                end else if (cnt == TIMEOUT_V) begin
                    timeout_hit = 1'b1;
                    state_next  = SEEK;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_cap <= '0;
        end else if (hi_load) begin
            hi_cap <= cnt;
        end
    end

    // Handshake: a result transfers on any cycle with meas_valid & meas_ready; while
    // meas_valid is high, period/high_time hold still; meas_ready alone does nothing.
    assign can_capture = !meas_valid || meas_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meas_valid  <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (capture_req && can_capture) begin
            meas_valid  <= 1'b1;
            period      <= cnt;
            high_time   <= hi_cap;
            timeout_err <= 1'b0;
        end else begin
            if (capture_req) overrun <= 1'b1;
            if (meas_valid && meas_ready) meas_valid <= 1'b0;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: table-driven waveforms plus hand-written corner sequences.
module tb_clock_period_meter;
    import clock_period_meter_pkg::*;

    localparam int W  = 16;
    localparam int TO = 64;

    logic         clock;
    logic         reset;
    logic         sig_in;
    logic         meas_valid;
    logic         meas_ready;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         timeout_err;
    logic         overrun;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];

    typedef struct {
        int unsigned  per;
        int unsigned  hi;
        int unsigned  n_cycles;
        logic [W-1:0] exp_period;
        logic [W-1:0] exp_high;
    } vec_t;

    vec_t vecs[6];

    clock_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_in),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .period      (period),
        .high_time   (high_time),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted output is compared against the oldest expectation.
    always @(negedge clock) begin
        #1;
        if (reset && meas_valid && meas_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_meas", 32'(period), 32'hFFFF_FFFF);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("meas_period", 32'(period), 32'(e[2*W-1:W]));
                check("meas_high", 32'(high_time), 32'(e[W-1:0]));
            end
        end
    end

    task automatic do_reset(input logic ready);
        reset      = 1'b0;
        sig_in     = 1'b0;
        meas_ready = ready;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
    endtask

    // Entered at a negedge; rise at entry, fall h cycles later, returns p cycles after entry.
    task automatic drive_cycle(input int unsigned p, input int unsigned h);
        sig_in = 1'b1;
        repeat (h) @(negedge clock);
        sig_in = 1'b0;
        repeat (p - h) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(meas_valid), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_high"}, 32'(high_time), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(SEEK));
    endtask

    initial begin
        int n;
        bit seen;

        reset      = 1'b0;
        sig_in     = 1'b0;
        meas_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("por");

        vecs[0] = '{20, 10, 4, 16'd20, 16'd10};
        vecs[1] = '{30, 7, 3, 16'd30, 16'd7};
        vecs[2] = '{30, 1, 3, 16'd30, 16'd1};
        vecs[3] = '{2, 1, 5, 16'd2, 16'd1};
        vecs[4] = '{40, 39, 3, 16'd40, 16'd39};
        vecs[5] = '{3, 2, 4, 16'd3, 16'd2};

        for (int i = 0; i < 6; i++) begin
            do_reset(1'b1);
            for (int c = 0; c < int'(vecs[i].n_cycles); c++) begin
                if (c > 0) exp_q.push_back({vecs[i].exp_period, vecs[i].exp_high});
                drive_cycle(vecs[i].per, vecs[i].hi);
            end
            repeat (5) @(negedge clock);
            check($sformatf("row%0d_drained", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("row%0d_overrun", i), 32'(overrun), 32'd0);
            check($sformatf("row%0d_timeout", i), 32'(timeout_err), 32'd0);
        end

        // Backpressure: first result held, later ones dropped.
        do_reset(1'b0);
        drive_cycle(20, 10);
        exp_q.push_back({16'd20, 16'd10});
        drive_cycle(24, 8);
        check("bp_hold_valid", 32'(meas_valid), 32'd1);
        check("bp_hold_period", 32'(period), 32'd20);
        check("bp_hold_overrun_pre", 32'(overrun), 32'd0);
        drive_cycle(28, 12);
        drive_cycle(20, 10);
        check("bp_held_period", 32'(period), 32'd20);
        check("bp_held_high", 32'(high_time), 32'd10);
        check("bp_overrun", 32'(overrun), 32'd1);
        meas_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("bp_valid_after", 32'(meas_valid), 32'd0);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Timeout while held high after a rise.
        do_reset(1'b1);
        sig_in = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (dbg_state == HIGH) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_enter_high", 32'(seen), 32'd1);
        n = 0;
        seen = 1'b0;
        while (n < 200) begin
            @(negedge clock);
            n++;
            if (timeout_err) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_fired", 32'(seen), 32'd1);
        check("to_latency", 32'(n), 32'(TO));
        check("to_state", 32'(dbg_state), 32'(SEEK));
        sig_in = 1'b0;
        repeat (5) @(negedge clock);
        check("to_sticky", 32'(timeout_err), 32'd1);
        drive_cycle(20, 10);
        exp_q.push_back({16'd20, 16'd10});
        drive_cycle(20, 10);
        exp_q.push_back({16'd20, 16'd10});
        drive_cycle(20, 10);
        check("to_cleared", 32'(timeout_err), 32'd0);
        check("to_drained", 32'(exp_q.size()), 32'd0);

        // Accept and capture in the same cycle.
        do_reset(1'b0);
        drive_cycle(20, 10);
        exp_q.push_back({16'd20, 16'd10});
        drive_cycle(26, 13);
        exp_q.push_back({16'd26, 16'd13});
        sig_in = 1'b1;
        repeat (2) @(negedge clock);
        meas_ready = 1'b1;
        @(negedge clock);
        meas_ready = 1'b0;
        check("sim_valid", 32'(meas_valid), 32'd1);
        check("sim_period", 32'(period), 32'd26);
        check("sim_high", 32'(high_time), 32'd13);
        check("sim_overrun", 32'(overrun), 32'd0);
        repeat (7) @(negedge clock);
        sig_in = 1'b0;
        repeat (10) @(negedge clock);
        meas_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("sim_drained", 32'(exp_q.size()), 32'd0);
        check("sim_overrun_end", 32'(overrun), 32'd0);

        // Reset pulse during HIGH abandons the measurement.
        do_reset(1'b1);
        sig_in = 1'b1;
        repeat (6) @(negedge clock);
        check("rst_in_high", 32'(dbg_state), 32'(HIGH));
        reset = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        sig_in = 1'b0;
        check_reset_values("rst_mid");
        @(negedge clock);
        drive_cycle(20, 10);
        check("rst_one_rise_no_valid", 32'(meas_valid), 32'd0);
        exp_q.push_back({16'd20, 16'd10});
        drive_cycle(22, 11);
        exp_q.push_back({16'd22, 16'd11});
        drive_cycle(24, 12);
        repeat (3) @(negedge clock);
        check("rst_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
